// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: streams 22-bit words from synchronous program memory, resolves branches locally.
// Define IFU_STACK_GUARD_EN to halt with stack_err on return-stack overflow/underflow instead of wrapping.
module instr_fetch_unit #(
  parameter int          ADDR_W       = 11,
  parameter int          STACK_DEPTH  = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flag_z,
  input  logic              flag_p0,
  input  logic              flag_cy,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_ren,
  input  logic [21:0]       pm_rdata,
  output logic [21:0]       instruction,
  output logic              HOLD,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_err
);

  localparam logic [21:0] NOP_WORD = 22'h1FFFFF;
  localparam logic [21:0] RET_WORD = 22'h018000;
  localparam int          SP_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [21:0]       instr_q, instr_d;
  logic              hold_q, hold_d;
  logic              rd_valid_q, rd_valid_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push_en;
  logic [ADDR_W-1:0] push_data;
  logic [SP_W-1:0]   sp_inc, sp_dec;

  logic is_jump, is_jze, is_jp0, is_jcy, is_bsr, is_ret, taken;
  logic [ADDR_W-1:0] target;

`ifdef IFU_STACK_GUARD_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             guard_fault;
`endif

  assign pm_addr     = pm_addr_q;
  assign instruction = instr_q;
  assign HOLD        = hold_q;
  assign pc          = pc_q;
  assign pm_ren      = !stall && !rst && (state_q != HALT);

`ifdef IFU_STACK_GUARD_EN
  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  // Opcode decode of the word currently on the memory read port.
  always_comb begin
    is_jump = (pm_rdata[21:11] == 11'h400);
    is_jze  = (pm_rdata[21:11] == 11'h500);
    is_jp0  = (pm_rdata[21:11] == 11'h600);
    is_jcy  = (pm_rdata[21:11] == 11'h700);
    is_bsr  = (pm_rdata[21:10] == 12'h700);
    is_ret  = (pm_rdata == RET_WORD);
    taken   = is_jump || (is_jze && flag_z) || (is_jp0 && flag_p0) ||
              (is_jcy && flag_cy) || is_bsr || is_ret;
  end

  // Circular stack pointer arithmetic; also correct for non-power-of-two depths.
  always_comb begin
    sp_inc = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
    sp_dec = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : sp_q - SP_W'(1);
    if (is_bsr)
      target = ADDR_W'(pm_rdata[9:0]);
    else if (is_ret)
      target = stack_q[sp_dec];
    else
      target = ADDR_W'(pm_rdata[10:0]);
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pm_addr_d  = pm_addr_q;
    ra_d       = ra_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    hold_d     = hold_q;
    rd_valid_d = rd_valid_q;
    sp_d       = sp_q;
    push_en    = 1'b0;
    push_data  = ra_q + ADDR_W'(1);
`ifdef IFU_STACK_GUARD_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
    guard_fault = (is_bsr && (cnt_q == CNT_W'(STACK_DEPTH))) ||
                  (is_ret && (cnt_q == '0));
`endif

    unique case (state_q)
      RUN: begin
        if (stall) begin
          hold_d = 1'b1;
        end else if (!rd_valid_q) begin
          instr_d    = NOP_WORD;
          hold_d     = 1'b1;
          pm_addr_d  = pm_addr_q + ADDR_W'(1);
          ra_d       = pm_addr_q;
          rd_valid_d = 1'b1;
`ifdef IFU_STACK_GUARD_EN
        end else if (guard_fault) begin
          state_d = HALT;
          err_d   = 1'b1;
          instr_d = NOP_WORD;
          hold_d  = 1'b1;
`endif
        end else begin
          instr_d = pm_rdata;
          pc_d    = ra_q;
          hold_d  = 1'b0;
          ra_d    = pm_addr_q;
          if (is_bsr) begin
            push_en = 1'b1;
            sp_d    = sp_inc;
`ifdef IFU_STACK_GUARD_EN
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end else if (is_ret) begin
            sp_d    = sp_dec;
`ifdef IFU_STACK_GUARD_EN
            cnt_d   = cnt_q - CNT_W'(1);
`endif
          end
          if (taken) begin
            pm_addr_d  = target;
            rd_valid_d = 1'b0;
          end else begin
            pm_addr_d  = pm_addr_q + ADDR_W'(1);
            rd_valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        instr_d = NOP_WORD;
        hold_d  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pm_addr_q  <= ADDR_W'(RESET_VECTOR);
      ra_q       <= ADDR_W'(RESET_VECTOR);
      pc_q       <= '0;
      instr_q    <= NOP_WORD;
      hold_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      sp_q       <= '0;
`ifdef IFU_STACK_GUARD_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pm_addr_q  <= pm_addr_d;
      ra_q       <= ra_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      hold_q     <= hold_d;
      rd_valid_q <= rd_valid_d;
      sp_q       <= sp_d;
`ifdef IFU_STACK_GUARD_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Return-address storage needs no reset; the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (push_en && !rst)
      stack_q[sp_q] <= push_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a synchronous program memory model.
// Honours IFU_STACK_GUARD_EN to select the nested-call expectations.
module tb_instr_fetch_unit;

  localparam logic [21:0] NOP = 22'h1FFFFF;

  logic        clk = 1'b0;
  logic        rst, stall, flag_z, flag_p0, flag_cy;
  logic [10:0] pm_addr;
  logic        pm_ren;
  logic [21:0] pm_rdata;
  logic [21:0] instruction;
  logic        HOLD;
  logic [10:0] pc;
  logic        stack_err;

  logic [21:0] mem [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          path[$];

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flag_z     (flag_z),
    .flag_p0    (flag_p0),
    .flag_cy    (flag_cy),
    .pm_addr    (pm_addr),
    .pm_ren     (pm_ren),
    .pm_rdata   (pm_rdata),
    .instruction(instruction),
    .HOLD       (HOLD),
    .pc         (pc),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_ren) pm_rdata <= mem[pm_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic z, input logic p, input logic c);
    stall   = s;
    flag_z  = z;
    flag_p0 = p;
    flag_cy = c;
  endtask

  task automatic loadDefault();
    for (int i = 0; i < 2048; i++) mem[i] = 22'h0A0000 | 22'(i);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // p < 0 expects a bubble, otherwise MEM[p] presented as a new instruction at pc=p.
  task automatic expectStep(input string tag, input int p);
    tick();
    if (p < 0) begin
      checkOutput($sformatf("%s nop", tag), 32'(instruction), 32'(NOP));
      checkOutput($sformatf("%s hold", tag), 32'(HOLD), 32'd1);
    end else begin
      checkOutput($sformatf("%s instr", tag), 32'(instruction), 32'(mem[p]));
      checkOutput($sformatf("%s pc", tag), 32'(pc), 32'(p));
      checkOutput($sformatf("%s hold", tag), 32'(HOLD), 32'd0);
    end
  endtask

  task automatic runPath(input string tag);
    foreach (path[i]) expectStep($sformatf("%s[%0d]", tag, i), path[i]);
  endtask

  initial begin
    logic [21:0] word;
    logic        t;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state and sequential fetch
    loadDefault();
    doReset();
    checkOutput("rst instr", 32'(instruction), 32'(NOP));
    checkOutput("rst hold", 32'(HOLD), 32'd1);
    checkOutput("rst pc", 32'(pc), 32'd0);
    checkOutput("rst pm_addr", 32'(pm_addr), 32'd0);
    checkOutput("rst stack_err", 32'(stack_err), 32'd0);
    path = {-1, 0, 1, 2, 3};
    runPath("seq");

    // Unconditional jump
    loadDefault();
    mem[2] = 22'h200123;
    doReset();
    path = {-1, 0, 1, 2, -1, 'h123, 'h124};
    runPath("jump");

    // Conditional jumps: only the matching flag may redirect
    for (int op = 0; op < 3; op++) begin
      for (int tk = 0; tk < 2; tk++) begin
        case (op)
          0:       word = 22'h280050;
          1:       word = 22'h300050;
          default: word = 22'h380050;
        endcase
        t = (tk == 1);
        loadDefault();
        mem[4] = word;
        applyStimulus(1'b0, (op == 0) ? t : !t, (op == 1) ? t : !t, (op == 2) ? t : !t);
        doReset();
        path = {-1, 0, 1, 2, 3, 4};
        if (t) begin
          path.push_back(-1);
          path.push_back('h50);
          path.push_back('h51);
        end else begin
          path.push_back(5);
          path.push_back(6);
        end
        runPath($sformatf("cond%0d_t%0d", op, tk));
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Subroutine call and return
    loadDefault();
    mem[5]    = 22'h1C0040;
    mem['h40] = 22'h018000;
    doReset();
    path = {-1, 0, 1, 2, 3, 4, 5, -1, 'h40, -1, 6, 7};
    runPath("bsr");
    checkOutput("bsr stack_err", 32'(stack_err), 32'd0);

    // Stall while pc=1
    loadDefault();
    doReset();
    path = {-1, 0, 1};
    runPath("stall_pre");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d instr", i), 32'(instruction), 32'(mem[1]));
      checkOutput($sformatf("stall%0d hold", i), 32'(HOLD), 32'd1);
      checkOutput($sformatf("stall%0d pm_ren", i), 32'(pm_ren), 32'd0);
      checkOutput($sformatf("stall%0d pc", i), 32'(pc), 32'd1);
    end
    stall = 1'b0;
    path = {2, 3};
    runPath("stall_post");

    // Stall during a branch bubble, then reset during a stall
    loadDefault();
    mem[2] = 22'h200123;
    doReset();
    path = {-1, 0, 1, 2};
    runPath("bstall_pre");
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("bstall%0d hold", i), 32'(HOLD), 32'd1);
      checkOutput($sformatf("bstall%0d pm_addr", i), 32'(pm_addr), 32'h123);
    end
    stall = 1'b0;
    path = {-1, 'h123, 'h124};
    runPath("bstall_post");
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstwin pm_addr", 32'(pm_addr), 32'd0);
    checkOutput("rstwin instr", 32'(instruction), 32'(NOP));
    checkOutput("rstwin pc", 32'(pc), 32'd0);
    stall = 1'b0;
    path = {-1, 0, 1};
    runPath("rstwin");

    // Five nested calls into a four-entry stack
    loadDefault();
    mem[0]    = 22'h1C0010;
    mem['h10] = 22'h1C0020;
    mem['h20] = 22'h1C0030;
    mem['h30] = 22'h1C0040;
    mem['h40] = 22'h1C0050;
    mem['h50] = 22'h018000;
    mem['h41] = 22'h018000;
    mem['h31] = 22'h018000;
    mem['h21] = 22'h018000;
    doReset();
    path = {-1, 0, -1, 'h10, -1, 'h20, -1, 'h30};
    runPath("nest");
`ifdef IFU_STACK_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("halt%0d instr", i), 32'(instruction), 32'(NOP));
      checkOutput($sformatf("halt%0d hold", i), 32'(HOLD), 32'd1);
      checkOutput($sformatf("halt%0d err", i), 32'(stack_err), 32'd1);
      checkOutput($sformatf("halt%0d pm_ren", i), 32'(pm_ren), 32'd0);
    end
    doReset();
    checkOutput("halt rst err", 32'(stack_err), 32'd0);
    checkOutput("halt rst pm_ren", 32'(pm_ren), 32'd1);
    path = {-1, 0};
    runPath("halt_exit");
`else
    path = {-1, 'h40, -1, 'h50, -1, 'h41, -1, 'h31, -1, 'h21, -1, 'h11, 'h12};
    runPath("nest_ret");
    checkOutput("nest stack_err", 32'(stack_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
